// File: rtl/pipelined_addsub_pkg.sv
// Shared mode encodings and pipeline sizing for pipelined_addsub.
package pipelined_addsub_pkg;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    function automatic int unsigned calc_stages(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One CHUNK-bit add/subtract slice; bout_o is the carry (add) or borrow (subtract) out.
module addsub_chunk
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             bin_i,
    input  logic             mode_i,
    output logic [CHUNK-1:0] r_o,
    output logic             bout_o
);

    logic [CHUNK:0] ext_a;
    logic [CHUNK:0] ext_b;
    logic [CHUNK:0] ext_c;
    logic [CHUNK:0] sum;

    // The extra top bit is the carry on add and goes to 1 on any borrow on subtract.
    always_comb begin
        ext_a = {1'b0, a_i};
        ext_b = {1'b0, b_i};
        ext_c = {{CHUNK{1'b0}}, bin_i};
        if (mode_i == MODE_ADD) begin
            sum = ext_a + ext_b + ext_c;
        end else begin
            sum = ext_a - ext_b - ext_c;
        end
    end

    assign r_o    = sum[CHUNK-1:0];
    assign bout_o = sum[CHUNK];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, valid/ready handshake.
// Define PIPELINED_ADDSUB_OVERFLOW_EN to build signed-overflow tracking; otherwise o_overflow = 0.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_borrow_in,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_borrow_out,
    output logic             o_overflow
);

    localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);

    logic en;

    // Rank k holds the beat about to be resolved by slice k. Operands are shifted down so the
    // active slice always sits in the low CHUNK bits; finished slices enter res_q from the top.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] mode_q;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  res_q   [STAGES];

    logic [CHUNK-1:0]  slice_r    [STAGES];
    logic              slice_bout [STAGES];
    logic [WIDTH-1:0]  res_next   [STAGES];

    logic              out_valid_q;
    logic [WIDTH-1:0]  result_q;
    logic              bout_q;

    assign en      = i_ready | ~out_valid_q;
    assign o_ready = en;
    assign o_valid = out_valid_q;
    assign o_result = result_q;
    assign o_borrow_out = bout_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i    (a_q[k][CHUNK-1:0]),
            .b_i    (b_q[k][CHUNK-1:0]),
            .bin_i  (carry_q[k]),
            .mode_i (mode_q[k]),
            .r_o    (slice_r[k]),
            .bout_o (slice_bout[k])
        );

        assign res_next[k] = (res_q[k] >> CHUNK) | (WIDTH'(slice_r[k]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= '0;
            carry_q     <= '0;
            mode_q      <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            result_q    <= '0;
            bout_q      <= 1'b0;
        end else if (en) begin
            valid_q[0] <= i_valid;
            if (i_valid) begin
                a_q[0]     <= i_op1;
                b_q[0]     <= i_op2;
                res_q[0]   <= '0;
                carry_q[0] <= i_borrow_in;
                mode_q[0]  <= i_mode;
            end

            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    a_q[k]     <= a_q[k-1] >> CHUNK;
                    b_q[k]     <= b_q[k-1] >> CHUNK;
                    res_q[k]   <= res_next[k-1];
                    carry_q[k] <= slice_bout[k-1];
                    mode_q[k]  <= mode_q[k-1];
                end
            end

            out_valid_q <= valid_q[STAGES-1];
            if (valid_q[STAGES-1]) begin
                result_q <= res_next[STAGES-1];
                bout_q   <= slice_bout[STAGES-1];
            end
        end
    end

`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
    logic [STAGES-1:0] asign_q;
    logic [STAGES-1:0] bsign_q;
    logic              ovf_q;
    logic              ovf_d;
    logic              a_msb;
    logic              b_msb;
    logic              r_msb;

    always_comb begin
        a_msb = asign_q[STAGES-1];
        b_msb = bsign_q[STAGES-1];
        r_msb = slice_r[STAGES-1][CHUNK-1];
        if (mode_q[STAGES-1] == MODE_ADD) begin
            ovf_d = (a_msb == b_msb) && (r_msb != a_msb);
        end else begin
            ovf_d = (a_msb != b_msb) && (r_msb != a_msb);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            asign_q <= '0;
            bsign_q <= '0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            if (i_valid) begin
                asign_q[0] <= i_op1[WIDTH-1];
                bsign_q[0] <= i_op2[WIDTH-1];
            end
            for (int k = 1; k < STAGES; k++) begin
                if (valid_q[k-1]) begin
                    asign_q[k] <= asign_q[k-1];
                    bsign_q[k] <= bsign_q[k-1];
                end
            end
            if (valid_q[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign o_overflow = ovf_q;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=16, CHUNK=4, latency 4).
module tb_pipelined_addsub;

`ifdef PIPELINED_ADDSUB_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_op1;
    logic [15:0] i_op2;
    logic        i_borrow_in;
    logic        i_mode;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_result;
    logic        o_borrow_out;
    logic        o_overflow;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] vr [8];
    logic        vbin [8];
    logic        vmode [8];
    logic        vbo [8];
    logic        vov [8];

    pipelined_addsub #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op1        (i_op1),
        .i_op2        (i_op2),
        .i_borrow_in  (i_borrow_in),
        .i_mode       (i_mode),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_borrow_out (o_borrow_out),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    // Drives one beat into an idle pipeline and waits (bounded) for its result.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic bin,
                             input logic mode, output logic [15:0] r, output logic bo,
                             output logic ov, output int lat);
        @(negedge clk);
        i_op1 = a; i_op2 = b; i_borrow_in = bin; i_mode = mode;
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        r = o_result; bo = o_borrow_out; ov = o_overflow;
    endtask

    task automatic test_reset;
        logic [15:0] r; logic bo, ov; int lat;
        send_beat(16'h1234, 16'h1111, 1'b0, 1'b1, r, bo, ov, lat);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (o_valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_valid: got %b expected 0", o_valid); end
        vectors++; if (o_result !== 16'h0000) begin miscompares++;
            $display("FAIL reset_result: got %h expected 0000", o_result); end
        vectors++; if (o_borrow_out !== 1'b0) begin miscompares++;
            $display("FAIL reset_borrow: got %b expected 0", o_borrow_out); end
        vectors++; if (o_overflow !== 1'b0) begin miscompares++;
            $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
        vectors++; if (o_ready !== 1'b1) begin miscompares++;
            $display("FAIL reset_ready: got %b expected 1", o_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_subtract;
        logic [15:0] r; logic bo, ov; int lat;
        send_beat(16'h0005, 16'h0007, 1'b0, 1'b0, r, bo, ov, lat);
        vectors++; if (lat !== 4) begin miscompares++;
            $display("FAIL sub_latency: got %0d expected 4", lat); end
        vectors++; if (r !== 16'hFFFE) begin miscompares++;
            $display("FAIL sub_result: got %h expected fffe", r); end
        vectors++; if (bo !== 1'b1) begin miscompares++;
            $display("FAIL sub_borrow: got %b expected 1", bo); end
        vectors++; if (ov !== 1'b0) begin miscompares++;
            $display("FAIL sub_overflow: got %b expected 0", ov); end
    endtask

    task automatic test_borrow_ripple;
        logic [15:0] r; logic bo, ov; int lat;
        send_beat(16'h0000, 16'h0000, 1'b1, 1'b0, r, bo, ov, lat);
        vectors++; if (r !== 16'hFFFF) begin miscompares++;
            $display("FAIL ripple_result: got %h expected ffff", r); end
        vectors++; if (bo !== 1'b1) begin miscompares++;
            $display("FAIL ripple_borrow: got %b expected 1", bo); end
        vectors++; if (ov !== 1'b0) begin miscompares++;
            $display("FAIL ripple_overflow: got %b expected 0", ov); end
    endtask

    task automatic test_overflow;
        logic [15:0] r; logic bo, ov; int lat;
        send_beat(16'h7FFF, 16'h0001, 1'b0, 1'b1, r, bo, ov, lat);
        vectors++; if (r !== 16'h8000) begin miscompares++;
            $display("FAIL ovf_add_result: got %h expected 8000", r); end
        vectors++; if (bo !== 1'b0) begin miscompares++;
            $display("FAIL ovf_add_carry: got %b expected 0", bo); end
        vectors++; if (ov !== OVF_EN) begin miscompares++;
            $display("FAIL ovf_add_flag: got %b expected %b", ov, OVF_EN); end
        send_beat(16'h8000, 16'h0001, 1'b0, 1'b0, r, bo, ov, lat);
        vectors++; if (r !== 16'h7FFF) begin miscompares++;
            $display("FAIL ovf_sub_result: got %h expected 7fff", r); end
        vectors++; if (bo !== 1'b0) begin miscompares++;
            $display("FAIL ovf_sub_borrow: got %b expected 0", bo); end
        vectors++; if (ov !== OVF_EN) begin miscompares++;
            $display("FAIL ovf_sub_flag: got %b expected %b", ov, OVF_EN); end
    endtask

    task automatic test_back_to_back;
        int sent, got, stall, cyc;
        bit started;
        logic [15:0] fr; logic fb, fo;
        va[0] = 16'h1234; vb[0] = 16'h1111; vbin[0] = 0; vmode[0] = 1;
        vr[0] = 16'h2345; vbo[0] = 0; vov[0] = 0;
        va[1] = 16'h0001; vb[1] = 16'h0002; vbin[1] = 0; vmode[1] = 0;
        vr[1] = 16'hFFFF; vbo[1] = 1; vov[1] = 0;
        va[2] = 16'hFFFF; vb[2] = 16'h0001; vbin[2] = 0; vmode[2] = 1;
        vr[2] = 16'h0000; vbo[2] = 1; vov[2] = 0;
        va[3] = 16'hABCD; vb[3] = 16'hABCD; vbin[3] = 1; vmode[3] = 0;
        vr[3] = 16'hFFFF; vbo[3] = 1; vov[3] = 0;
        va[4] = 16'h4000; vb[4] = 16'h4000; vbin[4] = 0; vmode[4] = 1;
        vr[4] = 16'h8000; vbo[4] = 0; vov[4] = OVF_EN;
        va[5] = 16'h8000; vb[5] = 16'h0000; vbin[5] = 0; vmode[5] = 0;
        vr[5] = 16'h8000; vbo[5] = 0; vov[5] = 0;
        va[6] = 16'hF0F0; vb[6] = 16'h0F0F; vbin[6] = 1; vmode[6] = 1;
        vr[6] = 16'h0000; vbo[6] = 1; vov[6] = 0;
        va[7] = 16'h7000; vb[7] = 16'h9000; vbin[7] = 0; vmode[7] = 0;
        vr[7] = 16'hE000; vbo[7] = 1; vov[7] = OVF_EN;
        sent = 0; got = 0; stall = 0; cyc = 0; started = 0;
        fr = '0; fb = 0; fo = 0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_valid && !started) begin
                started = 1; stall = 3;
                fr = o_result; fb = o_borrow_out; fo = o_overflow;
            end
            i_ready = (stall == 0);
            if (sent < 8) begin
                i_valid = 1'b1; i_op1 = va[sent]; i_op2 = vb[sent];
                i_borrow_in = vbin[sent]; i_mode = vmode[sent];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (stall > 0) begin
                vectors++; if (o_ready !== 1'b0) begin miscompares++;
                    $display("FAIL stall_ready: got %b expected 0", o_ready); end
                if (stall < 3) begin
                    vectors++;
                    if (o_valid !== 1'b1 || o_result !== fr || o_borrow_out !== fb ||
                        o_overflow !== fo) begin
                        miscompares++;
                        $display("FAIL stall_frozen: got v%b %h/%b/%b expected v1 %h/%b/%b",
                                 o_valid, o_result, o_borrow_out, o_overflow, fr, fb, fo);
                    end
                end
                stall--;
            end else if (started) begin
                vectors++; if (o_valid !== 1'b1) begin miscompares++;
                    $display("FAIL stream_gap: got valid %b expected 1 at beat %0d", o_valid, got);
                end
            end
            if (o_valid && i_ready) begin
                vectors++;
                if (o_result !== vr[got] || o_borrow_out !== vbo[got] ||
                    o_overflow !== vov[got]) begin
                    miscompares++;
                    $display("FAIL stream_beat%0d: got %h/%b/%b expected %h/%b/%b", got,
                             o_result, o_borrow_out, o_overflow, vr[got], vbo[got], vov[got]);
                end
                got++;
            end
            if (i_valid && o_ready) sent++;
            @(posedge clk);
        end
        vectors++; if (got !== 8) begin miscompares++;
            $display("FAIL stream_count: got %0d beats expected 8", got); end
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1;
    endtask

    task automatic test_reset_midstream;
        logic [15:0] r; logic bo, ov; int lat;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_op1 = 16'h0100 + 16'(i); i_op2 = 16'h0001;
            i_borrow_in = 1'b0; i_mode = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++; if (o_valid !== 1'b0) begin miscompares++;
                $display("FAIL midrst_valid: got %b expected 0 at cycle %0d", o_valid, i); end
        end
        vectors++; if (o_result !== 16'h0000) begin miscompares++;
            $display("FAIL midrst_result: got %h expected 0000", o_result); end
        send_beat(16'h0010, 16'h0003, 1'b0, 1'b1, r, bo, ov, lat);
        vectors++; if (lat !== 4) begin miscompares++;
            $display("FAIL midrst_latency: got %0d expected 4", lat); end
        vectors++; if (r !== 16'h0013) begin miscompares++;
            $display("FAIL midrst_result2: got %h expected 0013", r); end
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op1 = '0; i_op2 = '0; i_borrow_in = 1'b0; i_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_subtract();
        test_borrow_ripple();
        test_overflow();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, pipelined add/subtract unit with a valid/ready handshake. It splits a WIDTH-bit operation into CHUNK-bit slices and resolves one slice per pipeline stage, passing the borrow or carry stage to stage. The result is bit-exact with a WIDTH-bit ripple chain, but the critical path is bounded by CHUNK. Sits between an operand source and a result consumer in datapath blocks where a full-width ripple chain would limit clock frequency.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per stage; STAGES = WIDTH/CHUNK (derived, not overridable).
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  operand beat valid.
- o_ready  out  1  unit can accept a beat this cycle.
- i_op1  in  WIDTH  minuend / addend A.
- i_op2  in  WIDTH  subtrahend / addend B.
- i_borrow_in  in  1  borrow-in (subtract) or carry-in (add).
- i_mode  in  1  0 = op1 − op2 − borrow_in; 1 = op1 + op2 + borrow_in.
- o_valid  out  1  result beat valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  WIDTH  result, modulo 2^WIDTH.
- o_borrow_out  out  1  borrow-out (mode 0) or carry-out (mode 1).
- o_overflow  out  1  two's-complement signed overflow (see Configuration).

## Operation
- Global pipeline enable: en = i_ready | ~o_valid. o_ready = en (combinational from i_ready and o_valid).
- Accept: i_valid & o_ready at a rising edge.
- Stage k (0..STAGES-1):
  - Computes result bits [k*CHUNK +: CHUNK] from the skewed operand slices and the borrow/carry out of stage k-1.
  - Stage 0 uses i_borrow_in.
  - Lower result bits and the upper operand slices travel with the beat; mode travels with the beat.
- o_borrow_out is the borrow/carry out of the final slice.
- Result is identical to a WIDTH-bit ripple subtractor/adder for all inputs.
- Overflow:
  - Mode 0: (a_msb ≠ b_msb) & (r_msb ≠ a_msb).
  - Mode 1: (a_msb = b_msb) & (r_msb ≠ a_msb).
- Stage data registers load only when en and the upstream stage is valid. o_result, o_borrow_out and o_overflow therefore hold their last value while o_valid = 0.
- Valid bits shift on every en. A bubble enters stage 0 when en & ~i_valid.

## Timing
- Reset: all valid bits, data registers, o_valid, o_result, o_borrow_out and o_overflow are 0. o_ready = 1 after reset (o_valid = 0).
- Latency: a beat accepted at edge N appears with o_valid = 1 after edge N+STAGES, provided there is no stall.
- Throughput: one beat per cycle while i_ready = 1.
- Stall: when o_valid = 1 and i_ready = 0, the whole pipeline freezes and o_ready = 0. Outputs stay stable and no beat is lost or duplicated.
- Simultaneous output handshake and new accept in the same cycle is legal.
- Beat order is preserved.
- Reset asserted mid-stream clears all in-flight beats immediately (asynchronous). No partial result is ever presented.

## Configuration
- PIPELINED_ADDSUB_OVERFLOW_EN:
  - Defined: sign bits are carried through the pipeline and o_overflow is computed per beat, aligned with o_result.
  - Undefined: o_overflow is tied to 0 and the sign-tracking registers are not built.
- The port list is identical in both builds.

## Structure
- Package pipelined_addsub_pkg:
  - Mode encodings MODE_SUB = 1'b0, MODE_ADD = 1'b1.
  - A function computing STAGES from WIDTH and CHUNK.
- Sub-module addsub_chunk: combinational CHUNK-bit slice with inputs a, b, bin, mode and outputs r, bout. One instance per stage in a generate loop.
- Top-level holds the handshake, the skew registers and the overflow logic.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, latency 4.
- Reset: assert i_rst_n = 0 mid-cycle → o_valid = 0, o_result = 0x0000, o_borrow_out = 0, o_overflow = 0, o_ready = 1.
- Subtract, mode 0: 0x0005 − 0x0007, borrow_in 0, accepted at cycle 0 → at cycle 4 o_valid = 1, o_result = 0xFFFE, o_borrow_out = 1, o_overflow = 0.
- Full borrow ripple: 0x0000 − 0x0000 with borrow_in 1 → 0xFFFF, o_borrow_out = 1 (borrow crosses all four stages).
- Overflow, with macro defined:
  - Mode 1: 0x7FFF + 0x0001 → 0x8000, carry 0, o_overflow = 1.
  - Mode 0: 0x8000 − 0x0001 → 0x7FFF, borrow 0, o_overflow = 1.
  - Without the macro, o_overflow = 0 for both.
- Back-pressure: stream 8 random beats back-to-back and hold i_ready = 0 for 3 cycles once o_valid rises → o_ready = 0 and outputs frozen during the stall. All 8 results match the reference model in order, with no gaps beyond the stall.
- Reset mid-stream: 3 beats in flight, pulse i_rst_n low → no o_valid after release until a new beat is accepted, which then returns after 4 cycles.
